// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multiply/divide controller.
//   - op_code encodings presented by the EX stage
//   - controller state encoding
//   - divider iteration count (tied to the 32-bit datapath)
//   - is_muldiv(): true for ops that occupy the unit for multiple cycles
package muldiv_pkg;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  // One restoring step per bit of the 32-bit dividend.
  localparam int DIV_ITER = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) ||
           (op == OP_DIV)  || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_step.sv
// div_iter_step: one combinational restoring-division step.
//   rem_i       : current partial remainder (always < divisor_i)
//   shift_bit_i : next dividend bit, shifted in at the LSB
//   divisor_i   : divisor magnitude (non-zero)
//   rem_o       : next partial remainder
//   q_bit_o     : quotient bit produced by this step
module div_iter_step (
  input  logic [31:0] rem_i,
  input  logic        shift_bit_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] rem_o,
  output logic        q_bit_o
);

  logic [31:0] trial_low;

  // The shifted trial value is 33 bits wide. If its MSB (rem_i[31]) is set
  // it already exceeds any 32-bit divisor; otherwise the low 32 bits decide.
  // The subtraction result is always < divisor, so 32 bits hold it exactly.
  always_comb begin
    trial_low = {rem_i[30:0], shift_bit_i};
    q_bit_o   = rem_i[31] | (trial_low >= divisor_i);
    rem_o     = q_bit_o ? (trial_low - divisor_i) : trial_low;
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle multiply/divide unit for the EX stage.
// Owns HI/LO, runs MULT/MULTU over MUL_LAT cycles and DIV/DIVU through a
// DIV_ITER-step restoring divider, services MTHI/MTLO and raises stall.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting; accepts mult/div, performs MTHI/MTLO writes
// MUL   | latency countdown; product written to HI/LO at cnt==0
// DIV   | one restoring step per cycle on operand magnitudes
// FIX   | apply signs (or divide-by-zero result), write HI/LO
//
// Ports:
//   clk, reset        : clock, async active-high reset
//   op_valid, op_code : EX-stage muldiv op request
//   src_a, src_b      : rs / rt operand values
//   flush             : abort in-flight op, block acceptance this cycle
//   stall             : hold pipeline front-end and EX
//   busy              : unit executing (MUL/DIV/FIX)
//   done              : one-cycle pulse when HI/LO take a mult/div result
//   hi, lo            : architectural HI/LO registers
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [5:0] MUL_CNT_INIT = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_CNT_INIT = 6'(DIV_ITER - 1);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;       // raw src_a (mult operand, div-by-zero HI)
  logic [31:0] b_q, b_d;       // mult operand, or divisor magnitude
  logic [31:0] quo_q, quo_d;   // dividend bits shift out, quotient bits in
  logic [31:0] rem_q, rem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        sgn_q, sgn_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        div0_q, div0_d;
  logic        done_q, done_d;

  logic        req_md;
  logic        op_signed;
  logic        a_neg;
  logic        b_neg;
  logic [63:0] prod;
  logic [31:0] step_rem;
  logic        step_qbit;

  assign req_md    = op_valid & ~flush & is_muldiv(op_code);
  assign op_signed = (op_code == OP_MULT) || (op_code == OP_DIV);
  assign a_neg     = op_signed & src_a[31];
  assign b_neg     = op_signed & src_b[31];

  // Sign-extending to 64 bits makes one unsigned 64-bit multiply give the
  // correct low 64 bits for both signed and unsigned operands.
  assign prod = {{32{sgn_q & a_q[31]}}, a_q} * {{32{sgn_q & b_q[31]}}, b_q};

  div_iter_step u_div_step (
    .rem_i       (rem_q),
    .shift_bit_i (quo_q[31]),
    .divisor_i   (b_q),
    .rem_o       (step_rem),
    .q_bit_o     (step_qbit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      div0_q  <= div0_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    div0_d  = div0_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_md) begin
          a_d   = src_a;
          sgn_d = op_signed;
          if ((op_code == OP_MULT) || (op_code == OP_MULTU)) begin
            b_d     = src_b;
            cnt_d   = MUL_CNT_INIT;
            state_d = ST_MUL;
          end else begin
            b_d     = b_neg ? -src_b : src_b;
            quo_d   = a_neg ? -src_a : src_a;
            rem_d   = '0;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            div0_d  = (src_b == '0);
            cnt_d   = DIV_CNT_INIT;
            state_d = (src_b == '0) ? ST_FIX : ST_DIV;
          end
        end else if (op_valid && !flush) begin
          if (op_code == OP_MTHI) hi_d = src_a;
          if (op_code == OP_MTLO) lo_d = src_a;
        end
      end
      ST_MUL: begin
        if (cnt_q == '0) begin
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      ST_DIV: begin
        rem_d = step_rem;
        quo_d = {quo_q[30:0], step_qbit};
        if (cnt_q == '0) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      ST_FIX: begin
        if (div0_q) begin
          lo_d = '1;
          hi_d = a_q;
        end else begin
          lo_d = qneg_q ? -quo_q : quo_q;
          hi_d = rneg_q ? -rem_q : rem_q;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush wins over any completion or MTHI/MTLO write this cycle.
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_comb begin
    busy  = (state_q != ST_IDLE);
    stall = busy | req_md;
    done  = done_q;
    hi    = hi_q;
    lo    = lo_q;
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op_code  (op_code),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  int          total  = 0;
  int          passed = 0;
  logic [31:0] hi_m   = '0;
  logic [31:0] lo_m   = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1. Presents the op, checks the combinational stall,
  // lets the accept edge happen and withdraws the request.
  task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int lat, input logic [31:0] ehi,
                       input logic [31:0] elo, input bit push);
    exp_t e;
    if (push) begin
      e.tag = tag; e.lat = lat; e.hi = ehi; e.lo = elo;
      sb.push_back(e);
    end
    op_valid = 1'b1; op_code = op; src_a = a; src_b = b;
    #1;
    chk({tag, "_stall_accept"}, 64'(stall), 64'd1);
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = OP_NONE;
  endtask

  // Waits (bounded) for done, then pops the scoreboard and compares.
  task automatic complete(input int start_n);
    exp_t e;
    int   n = start_n;
    bit   seen = 0;
    bit   stall_ok = 1;
    while (n < 80 && !seen) begin
      @(posedge clk); #1;
      n++;
      if (done) seen = 1;
      else stall_ok &= (stall === 1'b1);
    end
    if (sb.size() == 0) begin
      chk("sb_nonempty", 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({e.tag, "_latency"}, 64'(n), 64'(e.lat));
    chk({e.tag, "_stall_hold"}, 64'(stall_ok), 64'd1);
    chk({e.tag, "_hi"}, 64'(hi), 64'(e.hi));
    chk({e.tag, "_lo"}, 64'(lo), 64'(e.lo));
    hi_m = e.hi; lo_m = e.lo;
    @(posedge clk); #1;
    chk({e.tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    bit any_done;
    reset = 1'b1; op_valid = 1'b0; op_code = OP_NONE;
    src_a = '0; src_b = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);

    issue("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1);
    complete(0);
    issue("multu_max2", OP_MULTU, 32'hFFFF_FFFF, 32'd2, MUL_LAT, 32'h0000_0001, 32'hFFFF_FFFE, 1);
    complete(0);
    issue("multu_maxsq", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'hFFFF_FFFE, 32'h0000_0001, 1);
    complete(0);
    issue("mult_m1sq", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'h0, 32'h1, 1);
    complete(0);
    issue("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1);
    complete(0);
    issue("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, DIV_LAT, 32'h1, 32'hFFFF_FFFD, 1);
    complete(0);
    issue("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h10, DIV_LAT, 32'hF, 32'h0FFF_FFFF, 1);
    complete(0);
    issue("divu_by0", OP_DIVU, 32'd5, 32'd0, 1, 32'h5, 32'hFFFF_FFFF, 1);
    complete(0);
    issue("div_by0", OP_DIV, 32'hFFFF_FFF0, 32'd0, 1, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1);
    complete(0);
    issue("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'h0, 32'h8000_0000, 1);
    complete(0);

    // Op presented together with flush is not accepted.
    op_valid = 1'b1; op_code = OP_MULT; src_a = 32'd9; src_b = 32'd9; flush = 1'b1;
    #1;
    chk("flush_req_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    op_valid = 1'b0; flush = 1'b0; op_code = OP_NONE;
    chk("flush_req_busy", 64'(busy), 64'd0);
    chk("flush_req_hi", 64'(hi), 64'(hi_m));

    // MTHI, then a DIV aborted by flush in cycle 10.
    op_valid = 1'b1; op_code = OP_MTHI; src_a = 32'h1234_5678;
    #1;
    chk("mthi_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = OP_NONE;
    hi_m = 32'h1234_5678;
    chk("mthi_hi", 64'(hi), 64'(hi_m));
    chk("mthi_lo", 64'(lo), 64'(lo_m));
    issue("div_flushed", OP_DIV, 32'd9, 32'd4, 0, 32'h0, 32'h0, 0);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    chk("flush_busy_before", 64'(busy), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy_after", 64'(busy), 64'd0);
    chk("flush_hi", 64'(hi), 64'(hi_m));
    chk("flush_lo", 64'(lo), 64'(lo_m));
    any_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      any_done |= done;
    end
    chk("flush_no_done", 64'(any_done), 64'd0);

    // MTLO held by a busy DIVU, then issued on the edge after done.
    issue("divu_100_7", OP_DIVU, 32'd100, 32'd7, DIV_LAT, 32'h2, 32'hE, 1);
    repeat (3) @(posedge clk);
    #1;
    op_valid = 1'b1; op_code = OP_MTLO; src_a = 32'hCAFE_F00D;
    #1;
    chk("mtlo_stall", 64'(stall), 64'd1);
    @(posedge clk); #1;
    chk("mtlo_held_lo", 64'(lo), 64'(lo_m));
    complete(4);
    op_valid = 1'b0; op_code = OP_NONE;
    chk("mtlo_late_lo", 64'(lo), 64'hCAFE_F00D);
    chk("mtlo_late_hi", 64'(hi), 64'h2);

    // Asynchronous reset in the middle of a DIV.
    issue("div_reset", OP_DIV, 32'd50, 32'd3, 0, 32'h0, 32'h0, 0);
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_done", 64'(done), 64'd0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
